// File: rtl/calc_sequencer.sv
// calc_sequencer: sequences multi-chunk dot products through a pipelined calculation unit.
// Define CALC_SEQ_SAT_EN to saturate the accumulator instead of wrapping.
module calc_sequencer #(
    parameter int LANES    = 16,
    parameter int DATA_W   = 8,
    parameter int PSUM_W   = 20,
    parameter int CALC_LAT = 2,
    parameter int CNT_W    = 8,
    parameter int ACC_W    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_chunks,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_A,
    input  logic [LANES*DATA_W-1:0]   in_B,
    output logic [LANES*DATA_W-1:0]   calc_A,
    output logic [LANES*DATA_W-1:0]   calc_B,
    input  logic [PSUM_W-1:0]         calc_O,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          res_data
);
    typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] num, issue_cnt, ret_cnt;
    logic [CALC_LAT-1:0] tag;
    logic [ACC_W-1:0] acc, acc_nx;
    logic hs, last, ret, done;
    assign hs   = in_valid && in_ready;
    assign last = hs && issue_cnt == num - CNT_W'(1);
    assign ret  = tag[CALC_LAT-1];
    assign done = ret_cnt == num;
`ifdef CALC_SEQ_SAT_EN
    logic [ACC_W:0] sum;
    assign sum    = {1'b0, acc} + (ACC_W+1)'(calc_O);
    assign acc_nx = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nx = acc + ACC_W'(calc_O);
`endif
    always_comb begin
        state_nx  = state;
        busy      = state != IDLE;
        in_ready  = state == FEED;
        res_valid = state == RESULT;
        case (state)
            IDLE:   state_nx = start ? (num_chunks != '0 ? FEED : RESULT) : IDLE;
            FEED:   state_nx = last ? DRAIN : FEED;
            DRAIN:  state_nx = done ? RESULT : DRAIN;
            RESULT: state_nx = res_ready ? IDLE : RESULT;
            default: state_nx = IDLE;
        endcase
    end
    // The tag pipeline mirrors the unit latency so each returning psum is matched to an issued beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            calc_A    <= '0;
            calc_B    <= '0;
            tag       <= '0;
            num       <= '0;
            issue_cnt <= '0;
            ret_cnt   <= '0;
            acc       <= '0;
            res_data  <= '0;
        end else begin
            state  <= state_nx;
            calc_A <= hs ? in_A : '0;
            calc_B <= hs ? in_B : '0;
            tag    <= CALC_LAT'({tag, hs});
            if (state == IDLE && start) begin
                num       <= num_chunks;
                issue_cnt <= '0;
                ret_cnt   <= '0;
                acc       <= '0;
                res_data  <= '0;
            end else begin
                if (hs) issue_cnt <= issue_cnt + CNT_W'(1);
                if (ret) begin
                    ret_cnt <= ret_cnt + CNT_W'(1);
                    acc     <= acc_nx;
                end
                if (state == DRAIN && done) res_data <= acc;
            end
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed checks of calc_sequencer with a behavioural 2-cycle calculation unit.
// A second instance with ACC_W=20 covers wrap/saturation (CALC_SEQ_SAT_EN).
module tb_calc_sequencer;
    logic clk = 0, rst = 0, start = 0, in_valid = 0, res_ready = 0;
    logic [7:0] num_chunks = 0;
    logic [127:0] in_A = 0, in_B = 0;
    logic busy, in_ready, res_valid, busy_s, in_ready_s, res_valid_s;
    logic [127:0] calc_A, calc_B, calc_A_s, calc_B_s;
    logic [19:0] calc_O, calc_O_s;
    logic [31:0] res_data;
    logic [19:0] res_data_s;
    logic [7:0] av [8], bv [8];
    int cyc = 0, checks = 0, errors = 0;

    calc_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
        .calc_A(calc_A), .calc_B(calc_B), .calc_O(calc_O),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );
    calc_sequencer #(.ACC_W(20)) dut_s (
        .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks), .busy(busy_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_A(in_A), .in_B(in_B),
        .calc_A(calc_A_s), .calc_B(calc_B_s), .calc_O(calc_O_s),
        .res_valid(res_valid_s), .res_ready(res_ready), .res_data(res_data_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] dot(input logic [127:0] a, input logic [127:0] b);
        logic [19:0] s = 0;
        for (int i = 0; i < 16; i++) s += a[i*8 +: 8] * b[i*8 +: 8];
        return s;
    endfunction

    // One register stage: operands driven at edge k are sampled as calc_O at edge k+2.
    always @(posedge clk) begin
        calc_O   <= dot(calc_A, calc_B);
        calc_O_s <= dot(calc_A_s, calc_B_s);
    end

    task automatic check(input string t, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", t, got, exp);
        end
    endtask

    task automatic set_ops(input logic [7:0] a0, b0, a1, b1, a2, b2);
        for (int i = 0; i < 8; i++) begin av[i] = 8'hFF; bv[i] = 8'hFF; end
        av[0] = a0; bv[0] = b0; av[1] = a1; bv[1] = b1; av[2] = a2; bv[2] = b2;
    endtask

    task automatic job(input string t, input logic [7:0] n, input logic [31:0] vpat, input int stall,
                       input logic [31:0] exp, input bit chk_s, input logic [19:0] exp_s);
        int beats = 0, last_hs = -1, rv_edge = -1, st_edge;
        bit any_ready = 0, prev_hs = 0;
        logic [127:0] prev_a = 0, va;
        @(negedge clk);
        start = 1; num_chunks = n; res_ready = (stall == 0); in_valid = 0;
        @(negedge clk);
        start = 0; st_edge = cyc;
        for (int i = 0; i < 100 && rv_edge < 0; i++) begin
            check({t, "/calc_a"}, calc_A, prev_hs ? prev_a : 128'h0);
            any_ready |= in_ready;
            if (res_valid) rv_edge = cyc;
            else begin
                va = {16{av[beats % 8]}};
                in_valid = vpat[i % 32]; in_A = va; in_B = {16{bv[beats % 8]}};
                #1;
                any_ready |= in_ready;
                prev_hs = in_valid && in_ready; prev_a = va;
                if (prev_hs) begin beats++; last_hs = cyc + 1; end
                @(negedge clk);
            end
        end
        in_valid = 0;
        check({t, "/done_in_time"}, rv_edge >= 0, 1);
        check({t, "/beats"}, beats, n);
        check({t, "/ready_seen"}, any_ready, n != 0);
        check({t, "/res_data"}, res_data, exp);
        check({t, "/latency"}, n == 0 ? rv_edge - st_edge : rv_edge - last_hs, n == 0 ? 0 : 3);
        if (chk_s) check({t, "/res_data_acc20"}, res_data_s, exp_s);
        repeat (stall) begin
            check({t, "/hold_valid"}, res_valid, 1);
            check({t, "/hold_data"}, res_data, exp);
            check({t, "/hold_busy"}, busy, 1);
            @(negedge clk);
        end
        res_ready = 1;
        @(negedge clk);
        check({t, "/valid_dropped"}, res_valid, 0);
        check({t, "/idle"}, busy, 0);
        res_ready = 0;
    endtask

    initial begin
        bit stale = 0;
        #1;
        check("rst/busy", busy, 0);
        check("rst/in_ready", in_ready, 0);
        check("rst/res_valid", res_valid, 0);
        check("rst/res_data", res_data, 0);
        check("rst/calc_a", calc_A, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        job("one", 8'd1, 32'hFFFFFFFF, 0, 32'd1040400, 0, 20'd0);
        job("four", 8'd4, 32'hFFFFFFFF, 0, 32'd4161600, 0, 20'd0);
        set_ops(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6);
        job("gaps", 8'd3, 32'hFFFFFFE9, 5, 32'd704, 0, 20'd0);
        job("zero", 8'd0, 32'hFFFFFFFF, 0, 32'd0, 0, 20'd0);
        set_ops(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        // Abandon a 4-beat job after two accepted beats.
        @(negedge clk);
        start = 1; num_chunks = 8'd4;
        @(negedge clk);
        start = 0; in_valid = 1; in_A = '1; in_B = '1;
        repeat (2) @(negedge clk);
        in_valid = 0;
        check("abort/calc_a_live", calc_A, {128{1'b1}});
        #2 rst = 0;
        #1;
        check("abort/busy", busy, 0);
        check("abort/in_ready", in_ready, 0);
        check("abort/res_valid", res_valid, 0);
        check("abort/calc_a", calc_A, 0);
        check("abort/calc_b", calc_B, 0);
        check("abort/res_data", res_data, 0);
        repeat (3) @(negedge clk);
        rst = 1;
        repeat (6) begin
            @(negedge clk);
            stale |= res_valid | busy;
        end
        check("abort/no_stale", stale, 0);
        job("post_rst", 8'd1, 32'hFFFFFFFF, 0, 32'd1040400, 0, 20'd0);
`ifdef CALC_SEQ_SAT_EN
        job("acc20", 8'd2, 32'hFFFFFFFF, 0, 32'd2080800, 1, 20'hFFFFF);
`else
        job("acc20", 8'd2, 32'hFFFFFFFF, 0, 32'd2080800, 1, 20'd1032224);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
